controller: RTL and testbench
=============================

Name: controller

Overview:
- LED pattern generator driving a 16-LED bank from a 2-bit mode switch.
- Generates a 16-bit Johnson (twisted-ring) running-light pattern; each pattern step is paced by a programmable clock divider.
- The switch selects the mode: off, slow continuous, medium continuous, or fast one-shot.
- Sits between the board switch inputs and the LED outputs; runs on the single system clock.

Parameters:
- WIDTH, 16: number of LED outputs; the pattern has 2*WIDTH states.
- DIV_SLOW, 1000: clocks per pattern step in mode 1.
- DIV_MID, 500: clocks per pattern step in mode 2.
- DIV_FAST, 200: clocks per pattern step in mode 3.

Ports:
- SCLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- SW  input  2  mode select: 0 off, 1 slow, 2 medium, 3 fast one-shot.
- LD  output  WIDTH  LED drive; registered output.

Behaviour:
- Reset is synchronous and active-high. While RST=1 at a rising edge:
  - LD=0, divider count=0, step count=0, done=0, registered mode=0.
- SW is treated as already synchronous to SCLK; no input synchronizer. SW is sampled every edge into a registered mode.
- Mode change, i.e. an edge where SW != registered mode:
  - registered mode takes SW;
  - divider count=0, step count=0, done=0, LD=0.
  - No pattern step occurs on this edge.
- Mode 0: LD held at 0; divider idle.
- Modes 1, 2, 3: divider counts 0..DIV-1 using that mode's DIV parameter.
  - On the edge where the count equals DIV-1: the count wraps to 0 and the pattern advances one step.
- Pattern step (Johnson shift): LD_next = {LD[WIDTH-2:0], ~LD[WIDTH-1]}.
  - Sequence from 0: 0x0001, 0x0003, …, 0xFFFF, 0xFFFE, 0xFFFC, …, 0x8000, 0x0000.
  - This is 32 states, returning to 0 after 32 steps.
- Latency: after a mode-change edge, the first step (LD=0x0001) lands exactly DIV edges later. Each subsequent step follows every DIV edges.
- Modes 1 and 2: continuous; the pattern wraps from 0x0000 and repeats indefinitely.
- Mode 3 (one-shot):
  - Step counter (6 bits) increments on every step.
  - After the 32nd step, LD=0x0000 and done=1.
  - While done=1, the divider and pattern are frozen and LD stays 0x0000.
  - Only a mode change or reset clears done.
- Re-entering a mode (e.g. 3→0→3) restarts the pattern from 0 with a fresh divider.
- Simultaneous events: RST has priority over a mode change; a mode change has priority over a divider step on the same edge.
- Reset mid-operation: applies the reset values on the next edge regardless of mode or progress.
- Divider widths must hold the largest DIV-1 (10 bits for the defaults). There is no overflow path; the count always wraps at DIV-1.

Test Plan:
- Reset then SW=0 held for 1000 clocks -> LD=0x0000 throughout.
- SW 0→1 at edge E0 -> LD=0x0000 until E1000; LD=0x0001 at E1000, 0x0003 at E2000, 0xFFFF at E16000, 0x0000 at E32000. Continues: 0x0001 at E33000.
- SW 1→2 mid-pattern (LD≠0) -> LD=0 on the change edge; 0x0001 exactly 500 clocks later. A full 32-step cycle takes 16000 clocks and returns to 0x0000.
- SW 2→3 -> steps every 200 clocks. LD=0xFFFF at +3200, 0x8000 at +6200, 0x0000 at +6400. LD then stays 0x0000 for a further 2500+ clocks (stopped).
- SW 3→0→3 after the stop -> the one-shot restarts: LD=0x0001 200 clocks after re-entry.
- RST=1 for one edge in mode 1 with LD=0x00FF -> next edge LD=0x0000 and registered mode=0. With SW still 1, a mode change is detected on the following edge and the pattern restarts 1000 clocks later.

Source files
------------

// File: rtl/controller.sv
// LED pattern generator: a WIDTH-bit Johnson running light whose step rate
// is set by a per-mode clock divider; mode 3 runs the pattern once and stops.
module controller #(
  parameter int WIDTH    = 16,
  parameter int DIV_SLOW = 1000,
  parameter int DIV_MID  = 500,
  parameter int DIV_FAST = 200
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic [1:0]       SW,
  output logic [WIDTH-1:0] LD
);

  localparam int MAX_DIV_SM = (DIV_SLOW > DIV_MID) ? DIV_SLOW : DIV_MID;
  localparam int MAX_DIV    = (MAX_DIV_SM > DIV_FAST) ? MAX_DIV_SM : DIV_FAST;
  localparam int CNT_W      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam int STEPS      = 2 * WIDTH;
  localparam int STEP_W     = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_MID  = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]  div_last;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  ld_q, ld_d;
  logic              mode_change;
  logic              step_en;

  always_comb begin
    div_last = '0;
    unique case (mode_q)
      MODE_SLOW: div_last = CNT_W'(DIV_SLOW - 1);
      MODE_MID:  div_last = CNT_W'(DIV_MID - 1);
      MODE_FAST: div_last = CNT_W'(DIV_FAST - 1);
      default:   div_last = '0;
    endcase
  end

  assign mode_change = (SW != mode_q);
  assign step_en     = (mode_q != MODE_OFF) && !done_q && (div_cnt_q == div_last);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    mode_d     = mode_q;
    div_cnt_d  = div_cnt_q;
    step_cnt_d = step_cnt_q;
    done_d     = done_q;
    ld_d       = ld_q;

    if (mode_change) begin
      // A mode change wins over any step due on the same edge.
      mode_d     = mode_e'(SW);
      div_cnt_d  = '0;
      step_cnt_d = '0;
      done_d     = 1'b0;
      ld_d       = '0;
    end else if (mode_q == MODE_OFF) begin
      div_cnt_d  = '0;
      step_cnt_d = '0;
      ld_d       = '0;
    end else if (!done_q) begin
      if (step_en) begin
        div_cnt_d = '0;
        ld_d      = {ld_q[WIDTH-2:0], ~ld_q[WIDTH-1]};
        if (mode_q == MODE_FAST) begin
          step_cnt_d = step_cnt_q + 1'b1;
          // The final step of the one-shot lands on all-zeros, then freezes.
          if (step_cnt_q == STEP_W'(STEPS - 1)) begin
            done_d = 1'b1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      mode_q     <= MODE_OFF;
      div_cnt_q  <= '0;
      step_cnt_q <= '0;
      done_q     <= 1'b0;
      ld_q       <= '0;
    end else begin
      mode_q     <= mode_d;
      div_cnt_q  <= div_cnt_d;
      step_cnt_q <= step_cnt_d;
      done_q     <= done_d;
      ld_q       <= ld_d;
    end
  end

  assign LD = ld_q;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: directed milestones plus random mode/reset traffic,
// every edge compared against a tick-count model of the LED pattern.
module tb_controller;

  localparam int WIDTH    = 16;
  localparam int DIV_SLOW = 1000;
  localparam int DIV_MID  = 500;
  localparam int DIV_FAST = 200;

  logic             sclk = 1'b0;
  logic             rst  = 1'b0;
  logic [1:0]       sw   = 2'd0;
  logic [WIDTH-1:0] ld;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: selected mode and edges elapsed since entering it.
  int m_mode  = 0;
  int m_ticks = 0;

  controller #(
    .WIDTH   (WIDTH),
    .DIV_SLOW(DIV_SLOW),
    .DIV_MID (DIV_MID),
    .DIV_FAST(DIV_FAST)
  ) dut (
    .SCLK(sclk),
    .RST (rst),
    .SW  (sw),
    .LD  (ld)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  // k-th state of the twisted ring from zero: k ones filling from the LSB,
  // then (k-WIDTH) zeros filling from the LSB.
  function automatic logic [WIDTH-1:0] johnson(input int k);
    int j;
    logic [2*WIDTH-1:0] ones;
    j    = k % (2 * WIDTH);
    ones = '1;
    if (j <= WIDTH) return WIDTH'((64'd1 << j) - 64'd1);
    else            return WIDTH'(ones[WIDTH-1:0] << (j - WIDTH));
  endfunction

  function automatic int div_of(input int mode);
    case (mode)
      1:       return DIV_SLOW;
      2:       return DIV_MID;
      3:       return DIV_FAST;
      default: return 1;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] model_ld();
    int steps;
    if (m_mode == 0) return '0;
    steps = m_ticks / div_of(m_mode);
    if (m_mode == 3 && steps >= 2 * WIDTH) return '0;
    return johnson(steps);
  endfunction

  // One rising edge: advance the model with the inputs the DUT saw, then compare.
  task automatic tick();
    @(posedge sclk);
    if (rst) begin
      m_mode  = 0;
      m_ticks = 0;
    end else if (int'(sw) != m_mode) begin
      m_mode  = int'(sw);
      m_ticks = 0;
    end else if (m_mode != 0 && m_ticks < 1_000_000) begin
      m_ticks++;
    end
    #1;
    check("model", ld, model_ld());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int budget;
    int hold;

    rst = 1'b1;
    sw  = 2'd0;
    run(2);
    check("reset", ld, 16'h0000);
    rst = 1'b0;

    run(1000);
    check("off_hold", ld, 16'h0000);

    // Slow mode from a fresh start.
    sw = 2'd1;
    run(1);
    check("m1_change", ld, 16'h0000);
    run(999);
    check("m1_e999", ld, 16'h0000);
    run(1);
    check("m1_e1000", ld, 16'h0001);
    run(1000);
    check("m1_e2000", ld, 16'h0003);
    run(14000);
    check("m1_e16000", ld, 16'hFFFF);
    run(1000);
    check("m1_e17000", ld, 16'hFFFE);

    // Medium mode entered mid-pattern, full cycle and wrap.
    sw = 2'd2;
    run(1);
    check("m2_change", ld, 16'h0000);
    run(499);
    check("m2_e499", ld, 16'h0000);
    run(1);
    check("m2_e500", ld, 16'h0001);
    run(15500);
    check("m2_e16000", ld, 16'h0000);
    run(500);
    check("m2_wrap", ld, 16'h0001);

    // Fast one-shot: run through, then stay stopped.
    sw = 2'd3;
    run(1);
    check("m3_change", ld, 16'h0000);
    run(3200);
    check("m3_e3200", ld, 16'hFFFF);
    run(3000);
    check("m3_e6200", ld, 16'h8000);
    run(200);
    check("m3_e6400", ld, 16'h0000);
    run(2600);
    check("m3_stopped", ld, 16'h0000);

    // Leave and re-enter the one-shot.
    sw = 2'd0;
    run(5);
    sw = 2'd3;
    run(1);
    run(199);
    check("m3_re_e199", ld, 16'h0000);
    run(1);
    check("m3_re_e200", ld, 16'h0001);

    // Reset in slow mode with the pattern at 0x00FF.
    sw = 2'd1;
    run(1);
    run(8000);
    check("m1_e8000", ld, 16'h00FF);
    rst = 1'b1;
    run(1);
    check("rst_mid", ld, 16'h0000);
    rst = 1'b0;
    run(1);
    check("rst_redetect", ld, 16'h0000);
    run(999);
    check("rst_e999", ld, 16'h0000);
    run(1);
    check("rst_e1000", ld, 16'h0001);

    // Random mode switching with occasional resets.
    budget = 14000;
    while (budget > 0) begin
      sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        budget -= 1;
      end
      if ($urandom_range(0, 4) == 0) hold = $urandom_range(1, 7000);
      else                           hold = $urandom_range(1, 700);
      run(hold);
      budget -= hold;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
